lsu_seq: RTL

//  Sequencer for the combinational load/store datapath (lsu). Accepts one load/store per handshake from the

---
 rtl/rv_lsu_pkg.sv | 46 ++++
 rtl/lsu_seq.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_lsu_pkg.sv
// Shared definitions for the load/store unit: function codes, access-size
// decode, sequencer state encoding and the datapath word width.
package rv_lsu_pkg;

  localparam int XLEN = 32;

  // Function codes: bit 3 = store, bit 2 = unsigned load, bits 1:0 = size.
  localparam logic [3:0] F_LB  = 4'b0000;
  localparam logic [3:0] F_LH  = 4'b0001;
  localparam logic [3:0] F_LW  = 4'b0010;
  localparam logic [3:0] F_LBU = 4'b0100;
  localparam logic [3:0] F_LHU = 4'b0101;
  localparam logic [3:0] F_SB  = 4'b1000;
  localparam logic [3:0] F_SH  = 4'b1001;
  localparam logic [3:0] F_SW  = 4'b1010;

  // Sequencer states
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD0  = 3'd1;
  localparam logic [2:0] ST_RD1  = 3'd2;
  localparam logic [2:0] ST_WR0  = 3'd3;
  localparam logic [2:0] ST_WR1  = 3'd4;
  localparam logic [2:0] ST_RESP = 3'd5;

  function automatic logic func_legal(input logic [3:0] f);
    case (f)
      F_LB, F_LH, F_LW, F_LBU, F_LHU, F_SB, F_SH, F_SW: return 1'b1;
      default:                                          return 1'b0;
    endcase
  endfunction

  // Access size in bytes (1/2/4)
  function automatic logic [2:0] func_size(input logic [3:0] f);
    case (f[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // True when the access runs past the end of the first word.
  function automatic logic func_span(input logic [1:0] boff, input logic [3:0] f);
    return ({1'b0, boff} + func_size(f)) > 3'd4;
  endfunction

endpackage

// File: rtl/lsu_seq.sv
// lsu_seq: memory sequencer for the combinational lsu datapath.
// Accepts one load/store per handshake, fetches the 64-bit window
// {word@A+1, word@A} (A = effective address [31:2]) from 32-bit memory,
// hands it to the datapath and either returns the load result or writes
// the merged window back. The second beat is issued only when the access
// crosses a word boundary.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   req_valid/ready            request handshake (ready only in IDLE)
//   req_func/base/offset/wdata request fields
//   resp_valid/ready           response handshake, held until accepted
//   resp_rdata, resp_err       load result (0 for stores/errors), error flag
//   lsu_func/base/offset/reg_in  latched request fields to the datapath
//   lsu_mem_in                 assembled window {beat1, beat0}
//   lsu_addr/reg_out/mem_out   effective address, load result, merged window
//   mem_req/we/addr/wdata      registered beat request, held until mem_ack
//   mem_ack, mem_rdata         beat completion, read data valid with ack
import rv_lsu_pkg::*;

module lsu_seq #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_func,
  input  logic [31:0] req_base,
  input  logic [11:0] req_offset,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [3:0]  lsu_func,
  output logic [31:0] lsu_base,
  output logic [11:0] lsu_offset,
  output logic [31:0] lsu_reg_in,
  output logic [63:0] lsu_mem_in,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_reg_out,
  input  logic [63:0] lsu_mem_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  logic [2:0]    r_state, n_state;
  logic          r_first, n_first;
  logic [3:0]    r_func, n_func;
  logic [31:0]   r_base, n_base;
  logic [11:0]   r_offset, n_offset;
  logic [31:0]   r_wdata, n_wdata;
  logic [63:0]   r_win, n_win;
  logic [29:0]   r_word, n_word;
  logic          r_mem_req, n_mem_req;
  logic          r_mem_we, n_mem_we;
  logic [29:0]   r_mem_addr, n_mem_addr;
  logic [31:0]   r_mem_wdata, n_mem_wdata;
  logic [TW-1:0] r_tmo, n_tmo;
  logic          r_resp_valid, n_resp_valid;
  logic [31:0]   r_resp_rdata, n_resp_rdata;
  logic          r_resp_err, n_resp_err;
  logic          r_req_ready, n_req_ready;

  logic          w_hs, w_tmo, w_span, w_load, w_go_resp, w_go_err;
  logic [29:0]   w_word;
  logic [63:0]   w_win;

  assign w_hs   = r_mem_req & mem_ack;
  assign w_tmo  = (TIMEOUT != 0) && r_mem_req && !mem_ack && (r_tmo == TMO_LAST);
  assign w_span = func_span(lsu_addr[1:0], r_func);
  assign w_load = ~r_func[3];
  assign w_word = lsu_addr[31:2];

  // Read data is forwarded into the window during the ack cycle so the
  // datapath result (load value or merged store data) is already correct
  // at the edge that completes the beat; no extra settle cycle is needed.
  always_comb begin
    w_win = r_win;
    if (w_hs && r_state == ST_RD0) w_win[31:0]  = mem_rdata;
    if (w_hs && r_state == ST_RD1) w_win[63:32] = mem_rdata;
  end

  always_comb begin
    n_state      = r_state;
    n_first      = r_first;
    n_func       = r_func;
    n_base       = r_base;
    n_offset     = r_offset;
    n_wdata      = r_wdata;
    n_win        = r_win;
    n_word       = r_word;
    n_mem_req    = r_mem_req;
    n_mem_we     = r_mem_we;
    n_mem_addr   = r_mem_addr;
    n_mem_wdata  = r_mem_wdata;
    n_tmo        = (r_mem_req && !mem_ack) ? r_tmo + 1'b1 : r_tmo;
    n_resp_valid = r_resp_valid;
    n_resp_rdata = r_resp_rdata;
    n_resp_err   = r_resp_err;
    n_req_ready  = r_req_ready;
    w_go_resp    = 1'b0;
    w_go_err     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        n_req_ready = 1'b1;
        if (req_valid && r_req_ready) begin
          n_func      = req_func;
          n_base      = req_base;
          n_offset    = req_offset;
          n_wdata     = req_wdata;
          n_win       = '0;
          n_req_ready = 1'b0;
          if (!func_legal(req_func)) w_go_err = 1'b1;
          else begin
            n_state = ST_RD0;
            n_first = 1'b1;
          end
        end
      end

      ST_RD0: begin
        if (r_first) begin
          // The latched request reaches the datapath one cycle after
          // acceptance; lsu_addr is valid now, so the first beat is chosen
          // here. Aligned word stores skip the read entirely.
          n_first    = 1'b0;
          n_word     = w_word;
          n_mem_req  = 1'b1;
          n_mem_addr = w_word;
          n_tmo      = '0;
          if (r_func == F_SW && lsu_addr[1:0] == 2'b00) begin
            n_state     = ST_WR0;
            n_mem_we    = 1'b1;
            n_mem_wdata = lsu_mem_out[31:0];
          end else begin
            n_mem_we    = 1'b0;
            n_mem_wdata = '0;
          end
        end else if (w_hs) begin
          n_win[31:0] = mem_rdata;
          if (w_span) begin
            n_state    = ST_RD1;
            n_mem_addr = r_word + 30'd1;
            n_tmo      = '0;
          end else if (w_load) begin
            w_go_resp = 1'b1;
          end else begin
            n_state     = ST_WR0;
            n_mem_we    = 1'b1;
            n_mem_addr  = r_word;
            n_mem_wdata = lsu_mem_out[31:0];
            n_tmo       = '0;
          end
        end else if (w_tmo) begin
          w_go_err = 1'b1;
        end
      end

      ST_RD1: begin
        if (w_hs) begin
          n_win[63:32] = mem_rdata;
          if (w_load) w_go_resp = 1'b1;
          else begin
            n_state     = ST_WR0;
            n_mem_we    = 1'b1;
            n_mem_addr  = r_word;
            n_mem_wdata = lsu_mem_out[31:0];
            n_tmo       = '0;
          end
        end else if (w_tmo) begin
          w_go_err = 1'b1;
        end
      end

      ST_WR0: begin
        if (w_hs) begin
          if (w_span) begin
            n_state     = ST_WR1;
            n_mem_addr  = r_word + 30'd1;
            n_mem_wdata = lsu_mem_out[63:32];
            n_tmo       = '0;
          end else begin
            w_go_resp = 1'b1;
          end
        end else if (w_tmo) begin
          w_go_err = 1'b1;
        end
      end

      ST_WR1: begin
        if (w_hs)       w_go_resp = 1'b1;
        else if (w_tmo) w_go_err  = 1'b1;
      end

      ST_RESP: begin
        if (resp_ready) begin
          n_state      = ST_IDLE;
          n_resp_valid = 1'b0;
          n_resp_err   = 1'b0;
          n_resp_rdata = '0;
          n_req_ready  = 1'b1;
        end
      end

      default: n_state = ST_IDLE;
    endcase

    // Common exit into RESP: withdraw any beat and capture the result.
    if (w_go_resp || w_go_err) begin
      n_state      = ST_RESP;
      n_mem_req    = 1'b0;
      n_mem_we     = 1'b0;
      n_mem_addr   = '0;
      n_mem_wdata  = '0;
      n_resp_valid = 1'b1;
      n_resp_err   = w_go_err;
      n_resp_rdata = (w_go_resp && w_load) ? lsu_reg_out : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_first      <= 1'b0;
      r_func       <= '0;
      r_base       <= '0;
      r_offset     <= '0;
      r_wdata      <= '0;
      r_win        <= '0;
      r_word       <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_tmo        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_req_ready  <= 1'b0;
    end else begin
      r_state      <= n_state;
      r_first      <= n_first;
      r_func       <= n_func;
      r_base       <= n_base;
      r_offset     <= n_offset;
      r_wdata      <= n_wdata;
      r_win        <= n_win;
      r_word       <= n_word;
      r_mem_req    <= n_mem_req;
      r_mem_we     <= n_mem_we;
      r_mem_addr   <= n_mem_addr;
      r_mem_wdata  <= n_mem_wdata;
      r_tmo        <= n_tmo;
      r_resp_valid <= n_resp_valid;
      r_resp_rdata <= n_resp_rdata;
      r_resp_err   <= n_resp_err;
      r_req_ready  <= n_req_ready;
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign lsu_func   = r_func;
  assign lsu_base   = r_base;
  assign lsu_offset = r_offset;
  assign lsu_reg_in = r_wdata;
  assign lsu_mem_in = w_win;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

endmodule
